// File: rtl/pipe_sched_if.sv
// Request/response bundle between requesters and the pipe scheduler.
// master = requester side, slave = scheduler side.
interface pipe_sched_if #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_cf;
  logic [16*NREQ-1:0] req_data0;
  logic [16*NREQ-1:0] req_data1;

  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_data0;
  logic [15:0]        rsp_data1;

  modport master (
    output req_valid, req_cf, req_data0, req_data1,
    input  req_ready, rsp_valid, rsp_id, rsp_data0, rsp_data1
  );

  modport slave (
    input  req_valid, req_cf, req_data0, req_data1,
    output req_ready, rsp_valid, rsp_id, rsp_data0, rsp_data1
  );
endinterface

// File: rtl/pipe_sched.sv
// Round-robin scheduler sharing one scaling pipe; accept T -> pipe_en T+1 -> tagged rsp T+1+LAT.
// One grant per cycle via valid/ready; responses are single-cycle strobes with no backpressure.
module pipe_sched #(
  parameter int NREQ = 2,
  parameter int LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_enable,
  pipe_sched_if.slave bus,
  output logic        pipe_rst_n,
  output logic        pipe_en,
  output logic [1:0]  pipe_cf,
  output logic [15:0] pipe_data0,
  output logic [15:0] pipe_data1,
  input  logic [15:0] pipe_rdata0,
  input  logic [15:0] pipe_rdata1,
  output logic        busy,
  output logic [15:0] issue_cnt
);
  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] scan_id;
  logic [IDW-1:0] gnt_id;
  logic           gnt_any;
  logic [1:0]     sel_cf;
  logic [15:0]    sel_data0;
  logic [15:0]    sel_data1;
  logic [IDW-1:0] issue_id;
  logic [LAT-1:0] tag_vld;
  logic [IDW-1:0] tag_id [LAT];

  // Scan from lowest priority up to ptr so the last hit is the winner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    scan_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_id = IDW'((int'(ptr) + k) % NREQ);
      if (bus.req_valid[scan_id]) begin
        gnt_any = 1'b1;
        gnt_id  = scan_id;
      end
    end
    if (rst || !cfg_enable) begin
      gnt_any = 1'b0;
    end
  end

  assign bus.req_ready = gnt_any ? (NREQ'(1) << gnt_id) : '0;

  always_comb begin
    sel_cf    = bus.req_cf[int'(gnt_id) * 2 +: 2];
    sel_data0 = bus.req_data0[int'(gnt_id) * 16 +: 16];
    sel_data1 = bus.req_data1[int'(gnt_id) * 16 +: 16];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      pipe_en    <= 1'b0;
      pipe_cf    <= '0;
      pipe_data0 <= '0;
      pipe_data1 <= '0;
      issue_id   <= '0;
      issue_cnt  <= '0;
      tag_vld    <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      pipe_en <= gnt_any;
      if (gnt_any) begin
        ptr        <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        pipe_cf    <= sel_cf;
        pipe_data0 <= sel_data0;
        pipe_data1 <= sel_data1;
        issue_id   <= gnt_id;
        issue_cnt  <= issue_cnt + 16'd1;
      end
      // Tags march alongside the pipe so the id lines up with pipe_rdata.
      tag_vld[0] <= pipe_en;
      tag_id[0]  <= issue_id;
      for (int s = 1; s < LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  assign pipe_rst_n    = ~rst;
  assign bus.rsp_valid = tag_vld[LAT-1];
  assign bus.rsp_id    = tag_id[LAT-1];
  assign bus.rsp_data0 = pipe_rdata0;
  assign bus.rsp_data1 = pipe_rdata1;
  assign busy          = pipe_en | (|tag_vld);

  a_grant_onehot: assert property (@(posedge clk) $onehot0(bus.req_ready));
  a_grant_valid:  assert property (@(posedge clk) (bus.req_ready & ~bus.req_valid) == '0);
endmodule

// File: tb/tb_pipe_sched.sv
// Randomized bench for pipe_sched: behavioural pipe plus a timestamped transaction scoreboard.
// Directed phases cover single op, passthrough, fairness, cfg_enable, mid-flight reset and counter wrap.
module tb_pipe_sched;
  localparam int NREQ = 2;
  localparam int LAT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic        pipe_rst_n;
  logic        pipe_en;
  logic [1:0]  pipe_cf;
  logic [15:0] pipe_data0;
  logic [15:0] pipe_data1;
  logic [15:0] pipe_rdata0;
  logic [15:0] pipe_rdata1;
  logic        busy;
  logic [15:0] issue_cnt;

  pipe_sched_if #(.NREQ(NREQ)) bus ();

  pipe_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_enable (cfg_enable),
    .bus        (bus),
    .pipe_rst_n (pipe_rst_n),
    .pipe_en    (pipe_en),
    .pipe_cf    (pipe_cf),
    .pipe_data0 (pipe_data0),
    .pipe_data1 (pipe_data1),
    .pipe_rdata0(pipe_rdata0),
    .pipe_rdata1(pipe_rdata1),
    .busy       (busy),
    .issue_cnt  (issue_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] scale(input logic [15:0] x, input logic [1:0] cf);
    logic [31:0] p;
    if (x == 16'h0000 || x == 16'hFFFF) return x;
    p = 32'(x) * 32'(cf);
    return p[15:0];
  endfunction

  // Behavioural stand-in for the shared pipe: result visible LAT cycles after pipe_en.
  logic [15:0] stg0 [LAT];
  logic [15:0] stg1 [LAT];
  always @(posedge clk) begin
    if (!pipe_rst_n) begin
      for (int s = 0; s < LAT; s++) begin
        stg0[s] <= '0;
        stg1[s] <= '0;
      end
    end else begin
      if (pipe_en) begin
        stg0[0] <= scale(pipe_data0, pipe_cf);
        stg1[0] <= scale(pipe_data1, pipe_cf);
      end
      for (int s = 1; s < LAT; s++) begin
        stg0[s] <= stg0[s-1];
        stg1[s] <= stg1[s-1];
      end
    end
  end
  assign pipe_rdata0 = stg0[LAT-1];
  assign pipe_rdata1 = stg1[LAT-1];

  typedef struct {
    int          id;
    logic [15:0] d0;
    logic [15:0] d1;
    int          t;
  } op_t;

  op_t ops[$];
  int  m_ptr    = 0;
  int  m_cnt    = 0;
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Check this cycle against the scoreboard at negedge, then advance the model across the edge.
  task automatic tick();
    int              g;
    int              i;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_en;
    op_t             o;
    @(negedge clk);
    g       = -1;
    exp_rdy = '0;
    if (!rst && cfg_enable) begin
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (g < 0 && bus.req_valid[i]) g = i;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_en = 1'b0;
    if (ops.size() > 0) exp_en = (ops[$].t == cyc - 1);
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check("pipe_en", 32'(pipe_en), 32'(exp_en));
    check("busy", 32'(busy), 32'(ops.size() > 0));
    check("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
    check("pipe_rst_n", 32'(pipe_rst_n), 32'(!rst));
    if (ops.size() > 0 && ops[0].t + 1 + LAT == cyc) begin
      o = ops.pop_front();
      check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("rsp_id", 32'(bus.rsp_id), 32'(o.id));
      check("rsp_data0", 32'(bus.rsp_data0), 32'(o.d0));
      check("rsp_data1", 32'(bus.rsp_data1), 32'(o.d1));
    end else begin
      check("rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    if (rst) begin
      ops.delete();
      m_ptr = 0;
      m_cnt = 0;
    end else if (g >= 0) begin
      o.id = g;
      o.d0 = scale(bus.req_data0[16*g +: 16], bus.req_cf[2*g +: 2]);
      o.d1 = scale(bus.req_data1[16*g +: 16], bus.req_cf[2*g +: 2]);
      o.t  = cyc;
      ops.push_back(o);
      m_ptr = (g + 1) % NREQ;
      m_cnt = (m_cnt + 1) % 65536;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] cf,
                         input logic [15:0] d0, input logic [15:0] d1);
    bus.req_valid[i]        = v;
    bus.req_cf[2*i +: 2]    = cf;
    bus.req_data0[16*i +: 16] = d0;
    bus.req_data1[16*i +: 16] = d1;
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand_reqs();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'($urandom), 2'($urandom), rand_op(), rand_op());
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pipe_en"}, 32'(pipe_en), 32'd0);
    check({tag, "_pipe_cf"}, 32'(pipe_cf), 32'd0);
    check({tag, "_pipe_data0"}, 32'(pipe_data0), 32'd0);
    check({tag, "_pipe_data1"}, 32'(pipe_data1), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_issue_cnt"}, 32'(issue_cnt), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    cfg_enable    = 1'b1;
    bus.req_valid = '0;
    bus.req_cf    = '0;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;

    // single op on requester 0
    set_req(0, 1'b1, 2'd2, 16'h0003, 16'h0010);
    tick();
    check("single_pipe_en", 32'(pipe_en), 32'd1);
    set_req(0, 1'b0, 2'd0, 16'h0000, 16'h0000);
    tick();
    tick();
    check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("single_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("single_rsp_d0", 32'(bus.rsp_data0), 32'h0006);
    check("single_rsp_d1", 32'(bus.rsp_data1), 32'h0020);
    repeat (3) tick();

    // passthrough and truncation on requester 1
    set_req(1, 1'b1, 2'd3, 16'hFFFF, 16'h9000);
    tick();
    set_req(1, 1'b0, 2'd0, 16'h0000, 16'h0000);
    tick();
    tick();
    check("pass_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("pass_rsp_id", 32'(bus.rsp_id), 32'd1);
    check("pass_rsp_d0", 32'(bus.rsp_data0), 32'hFFFF);
    check("pass_rsp_d1", 32'(bus.rsp_data1), 32'hB000);
    repeat (3) tick();

    // fairness from reset with both requesters valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rand_reqs();
      bus.req_valid = '1;
      #1;
      check("fair_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    bus.req_valid = '0;
    repeat (4) tick();
    check("fair_issue_cnt", 32'(issue_cnt), 32'd6);

    // cfg_enable drop with two ops in flight
    rand_reqs();
    bus.req_valid = '1;
    tick();
    tick();
    cfg_enable = 1'b0;
    #1;
    check("cfg_ready_low", 32'(bus.req_ready), 32'd0);
    repeat (5) tick();
    check("cfg_busy_low", 32'(busy), 32'd0);
    cfg_enable    = 1'b1;
    bus.req_valid = '0;
    tick();

    // reset one cycle after two back-to-back accepts from requester 0
    set_req(0, 1'b1, 2'd1, 16'h1234, 16'h5678);
    tick();
    tick();
    rst           = 1'b1;
    bus.req_valid = '1;
    tick();
    check_reset_state("midrst");
    rst = 1'b0;
    #1;
    check("midrst_first_grant", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = '0;
    repeat (5) tick();

    // randomized traffic with occasional disable and reset
    for (int n = 0; n < 2000; n++) begin
      rand_reqs();
      cfg_enable = ($urandom_range(0, 9) != 0);
      rst        = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst           = 1'b0;
    cfg_enable    = 1'b1;
    bus.req_valid = '0;
    repeat (5) tick();

    // issue counter wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 65536; n++) begin
      set_req(n % NREQ, 1'b1, 2'($urandom), rand_op(), rand_op());
      tick();
    end
    check("wrap_zero", 32'(issue_cnt), 32'h0000);
    tick();
    check("wrap_one", 32'(issue_cnt), 32'h0001);
    bus.req_valid = '0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_sched.md
# pipe_sched

Round-robin scheduler that shares one `pipe` scaling datapath between NREQ requesters. It accepts one request per cycle over valid/ready and registers the operands into the pipe's input port. It tags each issued operation with its requester index and returns the pipe result with that tag after the fixed pipe latency. It sits directly in front of `pipe`, drives all of its inputs, and owns the pipe's enable.

## Interface
- NREQ, 2, number of requesters (2..8); IDW = max(1, clog2(NREQ))
- LAT, 2, cycles from pipe_en sampled high to result visible on pipe_rdata*
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- cfg_enable  in  1  1 = grants allowed; 0 = no new grants, in-flight operations still complete
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot grant; combinational from req_valid, rr pointer, cfg_enable
- req_cf  in  2*NREQ  scale factor, requester i at [2i+1:2i]
- req_data0  in  16*NREQ  operand 0, requester i at [16i+15:16i]
- req_data1  in  16*NREQ  operand 1, same packing
- pipe_rst_n  out  1  = ~rst, to pipe reset
- pipe_en, pipe_cf[1:0], pipe_data0[15:0], pipe_data1[15:0]  out  to pipe i_en/i_cf/i_data0/i_data1 (registered)
- pipe_rdata0, pipe_rdata1  in  16  from pipe o_data0/o_data1
- rsp_valid  out  1  result strobe, single cycle, no backpressure
- rsp_id  out  IDW  requester index of result
- rsp_data0, rsp_data1  out  16  result, combinational pass-through of pipe_rdata*
- busy  out  1  any operation issued or in flight
- issue_cnt  out  16  total accepted requests, wraps 0xFFFF -> 0x0000

## Operation
- Arbitration: rr pointer `ptr` (IDW bits). Scan i = ptr, ptr+1, … mod NREQ. Grant the first i with req_valid[i] = 1, only when cfg_enable = 1.
- At most one req_ready bit is high; it is high only while the matching valid is high. Transfer = req_valid[i] & req_ready[i].
- On transfer to i: ptr <= (i+1) mod NREQ. No transfer: ptr unchanged.
- Issue register, next cycle:
  - pipe_en <= transfer; pipe_cf/data0/data1 <= granted operands.
  - On no transfer: pipe_en <= 0; operand registers hold their value.
- Tag pipeline: LAT-stage shift of {valid, id}. Stage 0 loaded from the issue register (valid = pipe_en).
- Last stage drives rsp_valid/rsp_id. rsp_data* = pipe_rdata* with no extra register.
- The scheduler performs no arithmetic. Expected result, in the pipe, is:
  - operand unchanged if operand is 0x0000 or 0xFFFF;
  - else (operand * cf) truncated to 16 bits.
- busy = pipe_en | OR of all tag valid bits.
- issue_cnt increments by 1 per transfer.
- Reset (rst = 1 at an edge), all registered outputs cleared:
  - ptr = 0, pipe_en = 0, pipe_cf = 0, pipe_data0/1 = 0;
  - all tag valids = 0, so rsp_valid = 0, rsp_id = 0, busy = 0, issue_cnt = 0.
- Reset mid-operation: in-flight operations are dropped and produce no rsp_valid. req_ready = 0 while rst = 1.

## Timing
- Request accepted in cycle T:
  - pipe_en = 1 in T+1;
  - rsp_valid = 1 with result in T+1+LAT (T+3 for LAT = 2).
- Throughput: one request per cycle, back-to-back, any mix of requesters. Responses return in issue order, one per cycle.
- cfg_enable falling in cycle T: no grant in T. Earlier transfers still respond on schedule.
- All requesters idle: pipe_en stays 0 and the pipe holds its last data. No response is generated from stale pipe outputs.
- Single valid requester: granted every cycle regardless of ptr.

## Test plan
- Single op: req0 data0 = 0x0003, data1 = 0x0010, cf = 2, accepted T -> pipe_en in T+1; rsp_valid in T+3 with id 0, data0 = 0x0006, data1 = 0x0020.
- Passthrough/truncation: req1 data0 = 0xFFFF, data1 = 0x9000, cf = 3 -> rsp id 1, data0 = 0xFFFF, data1 = 0xB000.
- Fairness: NREQ = 2, both valid continuously for 6 cycles from reset -> grants 0,1,0,1,0,1; responses carry ids 0,1,0,1,0,1 in consecutive cycles; issue_cnt = 6.
- cfg_enable: drop to 0 with 2 ops in flight -> req_ready = 0, both responses still arrive, busy falls the cycle after the last rsp_valid.
- Reset mid-flight: assert rst one cycle after 2 back-to-back accepts -> no rsp_valid afterward; all outputs at reset values; ptr = 0, so the first post-reset grant goes to req0 when both are valid.
- Counter wrap: 65536 accepted requests from reset -> issue_cnt = 0x0000; one more -> 0x0001.
